// File: rtl/func_gen_pkg.sv
// Shared definitions for the function-generator control path: waveform codes,
// controller state encoding, divider defaults and the configuration record.
package func_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_TRI    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    SWEEP = 2'd3
  } state_t;

  localparam logic [31:0] PKG_DEFAULT_DIV = 32'd50;
  localparam logic [31:0] PKG_MIN_DIV     = 32'd1;
  localparam int unsigned LUT_SIZE        = 256;

  // One fully decoded configuration, as held in the shadow or active registers.
  typedef struct packed {
    wave_t       wave;
    logic [31:0] div;
    logic [31:0] div_end;
    logic [31:0] step;
    logic        sweep;
    logic        dir_up;
  } cfg_t;

  function automatic logic [31:0] clamp_div(input logic [31:0] value,
                                            input logic [31:0] min_value);
    return (value < min_value) ? min_value : value;
  endfunction

endpackage

// File: rtl/div_sweep_step.sv
// One saturating sweep step: moves cur toward div_end by step and flags arrival.
// Sums are formed 33 bits wide so neither direction can wrap.
module div_sweep_step (
  input  logic [31:0] cur,
  input  logic [31:0] step,
  input  logic [31:0] div_end,
  input  logic        dir_up,
  output logic [31:0] next,
  output logic        reached
);

  logic [32:0] cur_x;
  logic [32:0] step_x;
  logic [32:0] end_x;
  logic [32:0] sum_up;
  logic [32:0] lim_dn;

  assign cur_x  = {1'b0, cur};
  assign step_x = {1'b0, step};
  assign end_x  = {1'b0, div_end};
  assign sum_up = cur_x + step_x;
  // Going down, cur - step <= end is tested as cur <= end + step to avoid underflow.
  assign lim_dn = end_x + step_x;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    next    = cur;
    reached = 1'b0;
    if (dir_up) begin
      reached = (sum_up >= end_x);
      next    = reached ? div_end : sum_up[31:0];
    end else begin
      reached = (cur_x <= lim_dn);
      next    = reached ? div_end : (cur - step);
    end
  end

endmodule

// File: rtl/wave_gen_ctrl.sv
// Waveform controller: accepts configuration commands and applies them only at
// LUT wrap boundaries, optionally sweeping the divider one step per period.
module wave_gen_ctrl
  import func_gen_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DIV = PKG_DEFAULT_DIV,
  parameter logic [31:0] MIN_DIV     = PKG_MIN_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_wave,
  input  logic [31:0] cmd_div,
  input  logic        cmd_sweep_en,
  input  logic [31:0] cmd_div_end,
  input  logic [15:0] cmd_div_step,
  input  logic        wrap_pulse,
  input  logic        stop,
  output logic [1:0]  wave_sel,
  output logic [31:0] clk_div,
  output logic        gen_en,
  output logic        sweep_done,
  output logic        busy
);

  state_t      state;
  state_t      state_next;
  cfg_t        in_cfg;
  cfg_t        shadow;
  logic [31:0] act_end;
  logic [31:0] act_step;
  logic        act_dir_up;
  logic        accept;
  logic [31:0] sweep_next;
  logic        sweep_reached;

  // Decode and clamp the incoming command once, for both apply paths.
  always_comb begin
    in_cfg         = '0;
    in_cfg.wave    = wave_t'(cmd_wave);
    in_cfg.div     = clamp_div(cmd_div, MIN_DIV);
    in_cfg.div_end = clamp_div(cmd_div_end, MIN_DIV);
    in_cfg.step    = {16'd0, cmd_div_step};
    in_cfg.dir_up  = (in_cfg.div_end > in_cfg.div);
    in_cfg.sweep   = cmd_sweep_en && (cmd_div_step != 16'd0)
                     && (in_cfg.div != in_cfg.div_end);
  end

  assign accept = cmd_valid && cmd_ready;

  div_sweep_step u_step (
    .cur     (clk_div),
    .step    (act_step),
    .div_end (act_end),
    .dir_up  (act_dir_up),
    .next    (sweep_next),
    .reached (sweep_reached)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; an accept in SWEEP wins over a same-cycle wrap.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (accept)     state_next = in_cfg.sweep ? SWEEP : RUN;
        RUN:   if (accept)     state_next = PEND;
        PEND:  if (wrap_pulse) state_next = shadow.sweep ? SWEEP : RUN;
        SWEEP: begin
          if (accept)                         state_next = PEND;
          else if (wrap_pulse && sweep_reached) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    cmd_ready = (state != PEND) && !stop && !rst;
    busy      = (state != IDLE);
  end

  // Active outputs, sweep parameters and shadow configuration.
  always_ff @(posedge clk) begin
    // NOTE: the shadow register is explicitly cleared on reset so a command
    // pending when reset hits can never be applied afterwards.
    if (rst) begin
      wave_sel   <= WAVE_SINE;
      clk_div    <= DEFAULT_DIV;
      gen_en     <= 1'b0;
      sweep_done <= 1'b0;
      act_end    <= '0;
      act_step   <= '0;
      act_dir_up <= 1'b0;
      shadow     <= '0;
    end else begin
      sweep_done <= 1'b0;
      if (stop) begin
        gen_en <= 1'b0;
        shadow <= '0;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            wave_sel   <= in_cfg.wave;
            clk_div    <= in_cfg.div;
            act_end    <= in_cfg.div_end;
            act_step   <= in_cfg.step;
            act_dir_up <= in_cfg.dir_up;
            gen_en     <= 1'b1;
          end
          RUN: if (accept) shadow <= in_cfg;
          PEND: if (wrap_pulse) begin
            wave_sel   <= shadow.wave;
            clk_div    <= shadow.div;
            act_end    <= shadow.div_end;
            act_step   <= shadow.step;
            act_dir_up <= shadow.dir_up;
            gen_en     <= 1'b1;
          end
          SWEEP: begin
            if (accept) begin
              shadow <= in_cfg;
            end else if (wrap_pulse) begin
              clk_div    <= sweep_next;
              sweep_done <= sweep_reached;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_gen_ctrl.sv
// Table-driven bench for wave_gen_ctrl: each row drives one cycle of inputs,
// checks cmd_ready before the edge and the registered outputs after it.
module tb_wave_gen_ctrl;
  import func_gen_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_wave;
  logic [31:0] cmd_div;
  logic        cmd_sweep_en;
  logic [31:0] cmd_div_end;
  logic [15:0] cmd_div_step;
  logic        wrap_pulse;
  logic        stop;
  logic [1:0]  wave_sel;
  logic [31:0] clk_div;
  logic        gen_en;
  logic        sweep_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  wave;
    logic [31:0] div;
    logic        sweep;
    logic [31:0] dend;
    logic [15:0] step;
    logic        wrap;
    logic        stop;
    logic        e_rdy;
    logic [1:0]  e_wave;
    logic [31:0] e_div;
    logic        e_gen;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  wave_gen_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wave     (cmd_wave),
    .cmd_div      (cmd_div),
    .cmd_sweep_en (cmd_sweep_en),
    .cmd_div_end  (cmd_div_end),
    .cmd_div_step (cmd_div_step),
    .wrap_pulse   (wrap_pulse),
    .stop         (stop),
    .wave_sel     (wave_sel),
    .clk_div      (clk_div),
    .gen_en       (gen_en),
    .sweep_done   (sweep_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, check ready, clock, check registered outputs.
  task automatic apply(input vec_t v, input string tag);
    rst          = v.rst;
    cmd_valid    = v.valid;
    cmd_wave     = v.wave;
    cmd_div      = v.div;
    cmd_sweep_en = v.sweep;
    cmd_div_end  = v.dend;
    cmd_div_step = v.step;
    wrap_pulse   = v.wrap;
    stop         = v.stop;
    #1;
    check({tag, ".cmd_ready"}, {31'd0, cmd_ready}, {31'd0, v.e_rdy});
    @(posedge clk);
    #1;
    check({tag, ".wave_sel"},   {30'd0, wave_sel},   {30'd0, v.e_wave});
    check({tag, ".clk_div"},    clk_div,             v.e_div);
    check({tag, ".gen_en"},     {31'd0, gen_en},     {31'd0, v.e_gen});
    check({tag, ".busy"},       {31'd0, busy},       {31'd0, v.e_busy});
    check({tag, ".sweep_done"}, {31'd0, sweep_done}, {31'd0, v.e_done});
    @(negedge clk);
  endtask

  // Row helpers: a plain cycle (optional wrap/stop/rst) and a command cycle.
  function automatic vec_t idle_row(input logic r, input logic w, input logic s,
                                    input logic er, input logic [1:0] ew,
                                    input logic [31:0] ed, input logic eg,
                                    input logic eb, input logic edn);
    return '{r, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 16'd0, w, s, er, ew, ed, eg, eb, edn};
  endfunction

  function automatic vec_t cmd_row(input logic [1:0] wv, input logic [31:0] d,
                                   input logic sw, input logic [31:0] de,
                                   input logic [15:0] st, input logic w,
                                   input logic er, input logic [1:0] ew,
                                   input logic [31:0] ed, input logic eg,
                                   input logic eb, input logic edn);
    return '{1'b0, 1'b1, wv, d, sw, de, st, w, 1'b0, er, ew, ed, eg, eb, edn};
  endfunction

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wave = '0; cmd_div = '0; cmd_sweep_en = 1'b0;
    cmd_div_end = '0; cmd_div_step = '0; wrap_pulse = 1'b0; stop = 1'b0;

    // Reset with a command present: not ready, outputs at reset values.
    tbl.push_back('{1'b1, 1'b1, 2'd1, 32'd100, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0,
                    1'b0, 2'd0, 32'd50, 1'b0, 1'b0, 1'b0});
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd0, 32'd50, 0, 0, 0));
    // Accept in IDLE applies one cycle later.
    tbl.push_back(cmd_row(WAVE_TRI, 32'd100, 0, 32'd0, 16'd0, 0, 1, 2'd1, 32'd100, 1, 1, 0));
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd1, 32'd100, 1, 1, 0));
    // RUN accept goes to shadow; PEND blocks further commands for 20 cycles.
    tbl.push_back(cmd_row(WAVE_SINE, 32'd40, 0, 32'd0, 16'd0, 0, 1, 2'd1, 32'd100, 1, 1, 0));
    tbl.push_back(cmd_row(WAVE_SAW, 32'd7, 0, 32'd0, 16'd0, 0, 0, 2'd1, 32'd100, 1, 1, 0));
    for (int i = 0; i < 19; i++)
      tbl.push_back(idle_row(0, 0, 0, 0, 2'd1, 32'd100, 1, 1, 0));
    tbl.push_back(idle_row(0, 1, 0, 0, 2'd0, 32'd40, 1, 1, 0));
    tbl.push_back(idle_row(0, 0, 0, 1, 2'd0, 32'd40, 1, 1, 0));
    // Down sweep 100 -> 84 -> 70 (saturated), then it stays put.
    tbl.push_back(cmd_row(WAVE_SINE, 32'd100, 1, 32'd70, 16'd16, 0, 1, 2'd0, 32'd40, 1, 1, 0));
    tbl.push_back(idle_row(0, 1, 0, 0, 2'd0, 32'd100, 1, 1, 0));
    tbl.push_back(idle_row(0, 0, 0, 1, 2'd0, 32'd100, 1, 1, 0));
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd0, 32'd84, 1, 1, 0));
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd0, 32'd70, 1, 1, 1));
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd0, 32'd70, 1, 1, 0));
    // Up sweep with clamped start: 1 -> 4 -> 5 (saturated).
    tbl.push_back(cmd_row(WAVE_SQUARE, 32'd0, 1, 32'd5, 16'd3, 0, 1, 2'd0, 32'd70, 1, 1, 0));
    tbl.push_back(idle_row(0, 1, 0, 0, 2'd2, 32'd1, 1, 1, 0));
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd2, 32'd4, 1, 1, 0));
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd2, 32'd5, 1, 1, 1));
    // stop in PEND with a command present: discard, hold divider, ignore wraps.
    tbl.push_back(cmd_row(WAVE_TRI, 32'd9, 0, 32'd0, 16'd0, 0, 1, 2'd2, 32'd5, 1, 1, 0));
    tbl.push_back('{1'b0, 1'b1, 2'd3, 32'd11, 1'b0, 32'd0, 16'd0, 1'b0, 1'b1,
                    1'b0, 2'd2, 32'd5, 1'b0, 1'b0, 1'b0});
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd2, 32'd5, 0, 0, 0));
    // Reset mid-sweep returns everything to reset values.
    tbl.push_back(cmd_row(WAVE_SAW, 32'd200, 1, 32'd100, 16'd10, 0, 1, 2'd3, 32'd200, 1, 1, 0));
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd3, 32'd190, 1, 1, 0));
    tbl.push_back(idle_row(1, 1, 0, 0, 2'd0, 32'd50, 0, 0, 0));
    tbl.push_back(idle_row(0, 1, 0, 1, 2'd0, 32'd50, 0, 0, 0));

    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Accept and wrap in the same RUN cycle: that wrap must not apply the command.
    apply(cmd_row(WAVE_TRI, 32'd100, 0, 32'd0, 16'd0, 0, 1, 2'd1, 32'd100, 1, 1, 0), "same0");
    apply(cmd_row(WAVE_SINE, 32'd33, 0, 32'd0, 16'd0, 1, 1, 2'd1, 32'd100, 1, 1, 0), "same1");
    apply(idle_row(0, 0, 0, 0, 2'd1, 32'd100, 1, 1, 0), "same2");
    apply(idle_row(0, 1, 0, 0, 2'd0, 32'd33, 1, 1, 0), "same3");
    apply(idle_row(0, 0, 0, 1, 2'd0, 32'd33, 1, 1, 0), "same4");

    // Accept in SWEEP freezes the sweep; the shadow command lands on the next wrap.
    apply(cmd_row(WAVE_SINE, 32'd20, 1, 32'd60, 16'd10, 0, 1, 2'd0, 32'd33, 1, 1, 0), "frz0");
    apply(idle_row(0, 1, 0, 0, 2'd0, 32'd20, 1, 1, 0), "frz1");
    apply(idle_row(0, 1, 0, 1, 2'd0, 32'd30, 1, 1, 0), "frz2");
    apply(cmd_row(WAVE_SAW, 32'd8, 0, 32'd0, 16'd0, 1, 1, 2'd0, 32'd30, 1, 1, 0), "frz3");
    apply(idle_row(0, 1, 0, 0, 2'd3, 32'd8, 1, 1, 0), "frz4");
    apply(idle_row(0, 1, 0, 1, 2'd3, 32'd8, 1, 1, 0), "frz5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wave_gen_ctrl.md
Name: wave_gen_ctrl

Overview:
Control and scheduling block for the function-generator wave engines (LUT-based triangle, sine, square and saw generators behind the divider).
- Accepts configuration commands over a valid/ready handshake: waveform select, divider value, optional linear frequency sweep.
- Applies every change only at a waveform period boundary (LUT wrap), so the DAC never sees a truncated period.
- Drives wave_sel, clk_div and gen_en into the wave generators and the output mux.

Parameters:
DEFAULT_DIV, 32'd50, clk_div value after reset.
MIN_DIV, 32'd1, smallest legal clk_div; smaller command values are clamped up to it.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted this cycle
cmd_wave  input  2  waveform code (from func_gen_pkg)
cmd_div  input  32  start divider value
cmd_sweep_en  input  1  1 = sweep clk_div from cmd_div to cmd_div_end
cmd_div_end  input  32  sweep end divider value
cmd_div_step  input  16  sweep increment per period, zero-extended
wrap_pulse  input  1  1-cycle pulse from active generator when LUT index wraps
stop  input  1  halt output
wave_sel  output  2  active waveform code
clk_div  output  32  active divider value
gen_en  output  1  generator/divider enable
sweep_done  output  1  1-cycle pulse when sweep reaches end value
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, wave_sel=0, clk_div=DEFAULT_DIV, gen_en=0, sweep_done=0, shadow registers cleared. cmd_ready reads 0 while rst=1.
- cmd_ready is combinational: (state != PEND) && !stop && !rst. A command is accepted when cmd_valid && cmd_ready at a posedge.
- Clamping at accept: div = max(cmd_div, MIN_DIV); div_end = max(cmd_div_end, MIN_DIV).
- Sweep direction is latched at accept: dir_up = (div_end > div). All compares are unsigned 33-bit, so nothing wraps.
- States:
  - IDLE: gen_en=0. On accept, the command applies immediately. Next cycle: wave_sel, clk_div and gen_en=1 are updated. Next state is SWEEP if cmd_sweep_en && step != 0 && div != div_end, else RUN. wrap_pulse is ignored.
  - RUN: on accept, the command goes to shadow and state goes to PEND. clk_div and wave_sel hold.
  - PEND: cmd_ready=0. On wrap_pulse, shadow loads into the outputs on the next cycle, and the IDLE rule decides RUN or SWEEP. A wrap_pulse in the same cycle as the accept that entered PEND does not count; the next wrap applies it.
  - SWEEP: on each wrap_pulse, clk_div becomes clk_div ± step (+ if dir_up).
    - If the result reaches or passes div_end, clk_div=div_end, sweep_done pulses 1 cycle with that update, and state goes to RUN.
    - An accept in SWEEP goes to PEND and freezes the sweep.
- stop: priority below rst, above everything else. Next cycle: gen_en=0, state=IDLE, shadow discarded, no sweep_done. wave_sel and clk_div hold their values.
- Latency from an applied change (IDLE accept, or wrap_pulse in PEND/SWEEP) to outputs is exactly 1 cycle.
- sweep_done never asserts except on the final sweep update.
- rst mid-sweep or mid-PEND returns all registers to reset values; no partial apply.

Decomposition:
- func_gen_pkg holds:
  - waveform codes: WAVE_SINE=0, WAVE_TRI=1, WAVE_SQUARE=2, WAVE_SAW=3
  - state encoding: IDLE, RUN, PEND, SWEEP
  - DEFAULT_DIV and MIN_DIV defaults
  - LUT_SIZE
- One combinational sub-module, div_sweep_step.
  - Inputs: cur, step, end, dir_up.
  - Outputs: next value and reached flag, using saturating 33-bit arithmetic.
  - Reused later by an amplitude-sweep controller.

Test Plan:
1. Reset, then accept {wave=TRI, div=100, sweep=0} -> 1 cycle later wave_sel=1, clk_div=100, gen_en=1, busy=1; cmd_ready=1.
2. In RUN, accept {wave=SINE, div=40} -> cmd_ready=0, outputs unchanged; wrap_pulse 20 cycles later -> next cycle wave_sel=0, clk_div=40, cmd_ready=1.
3. Accept {div=100, end=70, step=16, sweep=1} -> clk_div 100→84→70 on successive wraps; sweep_done pulses once with 70; state RUN; further wraps leave clk_div at 70.
4. Accept {div=0, end=5, step=3, sweep=1} -> clk_div=1 (clamped), then 4, then 5 with sweep_done (up direction, saturated).
5. Accept and wrap_pulse in the same cycle while in RUN -> no apply on that wrap; apply on the following wrap.
6. stop asserted during PEND with cmd_valid=1 -> cmd_ready=0; next cycle gen_en=0, IDLE, clk_div unchanged; a later wrap_pulse changes nothing. Also: rst mid-SWEEP -> clk_div=50, gen_en=0.
